// File: rtl/joy_db15_scanner_if.sv
// Pin-level bundle between the DB15 shift-register chain, the scanner and the decoded joystick state.
interface joy_db15_scanner_if;
  logic        JOY_DATA;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_strobe;

  modport master (
    input  JOY_DATA,
    output JOY_CLK, JOY_LOAD, joystick1, joystick2, frame_strobe
  );

  modport slave (
    output JOY_DATA,
    input  JOY_CLK, JOY_LOAD, joystick1, joystick2, frame_strobe
  );
endinterface

// File: rtl/joy_db15_scanner.sv
// Scans a 32-bit DB15 shift-register chain (two players) and publishes the decoded state
// only when two consecutive frames agree.
module joy_db15_scanner #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned GAP_TICKS = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  joy_db15_scanner_if.master joy
);
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned GAP_W  = 12;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned WORD_W = 32;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  logic [1:0]        rst_sync_q;
  logic              ready;
  logic [DIV_W-1:0]  div_q;
  logic              tick;
  logic              armed_q;

  state_t            state_q, state_d;
  logic              load_cnt_q, load_cnt_d;
  logic              phase_q, phase_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [WORD_W-1:0] w_q, w_d;
  logic [WORD_W-1:0] p_q, p_d;
  logic              gap_entry;

  logic              joy_clk_c, joy_load_c, strobe_c;
  logic              joy_clk_q, joy_load_q, strobe_q;
  logic [15:0]       joy1_q, joy2_q;

  // Release of reset is brought into the clk domain before anything starts counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign ready = rst_sync_q[1];

  // Free-running tick divider; armed_q keeps the first tick after release from starting a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      if (!ready || tick) div_q <= '0;
      else                div_q <= div_q + DIV_W'(1);
      if (tick) armed_q <= 1'b1;
    end
  end
  assign tick = ready && (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      load_cnt_q <= 1'b0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      gap_q      <= '0;
      w_q        <= '0;
      p_q        <= '1;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      w_q        <= w_d;
      p_q        <= p_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    w_d        = w_q;
    gap_entry  = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: if (enable && armed_q) begin
          state_d    = LOAD;
          load_cnt_d = 1'b0;
        end
        LOAD: if (load_cnt_q) begin
          state_d = SHIFT;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          load_cnt_d = 1'b1;
        end
        SHIFT: if (!phase_q) begin
          // Sample while JOY_CLK is still low; the chain shifts on the following rise.
          w_d[bit_q] = ~joy.JOY_DATA;
          phase_d    = 1'b1;
        end else if (bit_q == BIT_LAST) begin
          state_d   = GAP;
          gap_d     = '0;
          phase_d   = 1'b0;
          gap_entry = 1'b1;
        end else begin
          bit_d   = bit_q + BIT_W'(1);
          phase_d = 1'b0;
        end
        GAP: if (gap_q == GAP_LAST) begin
          state_d    = enable ? LOAD : IDLE;
          load_cnt_d = 1'b0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
    p_d = gap_entry ? w_q : p_q;
  end

  // Pin levels follow the next state so they change on the same edge as the FSM.
  always_comb begin
    joy_clk_c  = (state_d == SHIFT) && phase_d;
    joy_load_c = (state_d != LOAD);
    strobe_c   = gap_entry && (w_q == p_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy_clk_q  <= 1'b0;
      joy_load_q <= 1'b1;
      strobe_q   <= 1'b0;
      joy1_q     <= '0;
      joy2_q     <= '0;
    end else begin
      joy_clk_q  <= joy_clk_c;
      joy_load_q <= joy_load_c;
      strobe_q   <= strobe_c;
      if (strobe_c) begin
        joy1_q <= w_q[15:0];
        joy2_q <= w_q[31:16];
      end
    end
  end

  assign joy.JOY_CLK      = joy_clk_q;
  assign joy.JOY_LOAD     = joy_load_q;
  assign joy.frame_strobe = strobe_q;
  assign joy.joystick1    = joy1_q;
  assign joy.joystick2    = joy2_q;
endmodule
